// File: rtl/echo_arb_pkg.sv
// Shared helpers for the Echo request arbiter: width math, stat width and the
// round-robin pick function used by the issue path.
package echo_arb_pkg;

    localparam int STAT_W    = 16;
    localparam int MAX_NREQ  = 8;
    localparam int MAX_TAG_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] idx;
    } pick_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // First asserted request scanning ptr, ptr+1, ... modulo n.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0]  req,
                                      input logic [MAX_TAG_W-1:0] ptr,
                                      input int                   n);
        pick_t p;
        int    idx;
        p = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (!p.valid && req[idx]) begin
                    p.valid = 1'b1;
                    p.idx   = MAX_TAG_W'(idx);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/echo_tag_fifo.sv
// In-order tag FIFO holding the requester index of each outstanding say,
// so the matching heard can be routed back to its issuer.
module echo_tag_fifo
    import echo_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        din_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        head_o,
    output logic [clog2(DEPTH):0]   count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int AW    = clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: storage is not reset; entries are only read after being written.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch.
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use <= so all of them sample pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/echo_req_arbiter.sv
// Round-robin arbiter sharing one in-order Echo say/heard service among NREQ
// requesters. Define ECHO_REQ_ARBITER_STATS_EN to add grant/full-stall counters.
module echo_req_arbiter
    import echo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [NREQ-1:0]    req__ENA,
    input  logic [NREQ*DW-1:0] req_meth,
    input  logic [NREQ*DW-1:0] req_v,
    output logic [NREQ-1:0]    req__RDY,
    output logic               say__ENA,
    output logic [DW-1:0]      say_meth,
    output logic [DW-1:0]      say_v,
    input  logic               say__RDY,
    input  logic               heard__ENA,
    input  logic [DW-1:0]      heard_meth,
    input  logic [DW-1:0]      heard_v,
    output logic               heard__RDY,
    output logic [NREQ-1:0]    rsp__ENA,
    output logic [DW-1:0]      rsp_meth,
    output logic [DW-1:0]      rsp_v,
    input  logic [NREQ-1:0]    rsp__RDY,
    output logic               busy
`ifdef ECHO_REQ_ARBITER_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_grants,
    output logic [STAT_W-1:0]      stat_fullstall
`endif
);

    localparam int TAG_W = clog2(NREQ);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0] winner, head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             can_issue, rsp_fire;
    pick_t            pick;

    // Reset gates the handshakes so they drop asynchronously even when empty.
    assign can_issue = nRST && say__RDY && !fifo_full;
    assign pick      = rr_pick(MAX_NREQ'(req__ENA), MAX_TAG_W'(rr_ptr_q), NREQ);
    assign winner    = pick.idx[TAG_W-1:0];
    assign say__ENA  = can_issue && pick.valid;

    assign heard__RDY = !fifo_empty && rsp__RDY[head];
    assign rsp_fire   = heard__ENA && heard__RDY;
    assign busy       = (fifo_count != '0);

    always_comb begin
        req__RDY = '0;
        say_meth = '0;
        say_v    = '0;
        rr_ptr_d = rr_ptr_q;
        if (say__ENA) begin
            req__RDY[winner] = 1'b1;
            say_meth         = req_meth[winner*DW +: DW];
            say_v            = req_v[winner*DW +: DW];
            rr_ptr_d         = TAG_W'((int'(pick.idx) + 1) % NREQ);
        end
    end

    always_comb begin
        rsp__ENA = '0;
        rsp_meth = '0;
        rsp_v    = '0;
        if (rsp_fire) begin
            rsp__ENA[head] = 1'b1;
            rsp_meth       = heard_meth;
            rsp_v          = heard_v;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

    echo_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .CLK     (CLK),
        .nRST    (nRST),
        .push_i  (say__ENA),
        .din_i   (winner),
        .pop_i   (rsp_fire),
        .head_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef ECHO_REQ_ARBITER_STATS_EN
    logic [STAT_W-1:0] grant_cnt_q [NREQ];
    logic [STAT_W-1:0] stall_cnt_q;
    logic              stall;

    assign stall = (|req__ENA) && fifo_full && say__RDY;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREQ; i++) grant_cnt_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (say__ENA && winner == TAG_W'(i) && grant_cnt_q[i] != '1)
                    grant_cnt_q[i] <= grant_cnt_q[i] + STAT_W'(1);
            end
            if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + STAT_W'(1);
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NREQ; i++) stat_grants[i*STAT_W +: STAT_W] = grant_cnt_q[i];
    end
    assign stat_fullstall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_echo_req_arbiter.sv
// Self-checking bench for echo_req_arbiter: a queue-based reference model of
// the arbiter plus an in-order Echo responder, directed scenarios and random traffic.
module tb_echo_req_arbiter;

    localparam int NREQ  = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int VW    = NREQ + 1 + DW + DW + 1 + NREQ + DW + DW + 1;

    logic               CLK = 1'b0;
    logic               nRST = 1'b0;
    logic [NREQ-1:0]    req__ENA, req__RDY, rsp__ENA;
    logic [NREQ*DW-1:0] req_meth, req_v;
    logic               say__ENA, say__RDY, heard__ENA, heard__RDY, busy;
    logic [DW-1:0]      say_meth, say_v, heard_meth, heard_v, rsp_meth, rsp_v;
    logic [NREQ-1:0]    rsp__RDY;
`ifdef ECHO_REQ_ARBITER_STATS_EN
    logic [NREQ*16-1:0] stat_grants;
    logic [15:0]        stat_fullstall;
`endif

    // Bench-side drive variables
    logic [NREQ-1:0] drv_ena;
    logic [DW-1:0]   drv_meth [NREQ];
    logic [DW-1:0]   drv_v    [NREQ];

    always #5 CLK = ~CLK;

    assign req__ENA = drv_ena;
    always_comb begin
        req_meth = '0;
        req_v    = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_meth[i*DW +: DW] = drv_meth[i];
            req_v[i*DW +: DW]    = drv_v[i];
        end
    end

    echo_req_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .DW(DW)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .req__ENA   (req__ENA),
        .req_meth   (req_meth),
        .req_v      (req_v),
        .req__RDY   (req__RDY),
        .say__ENA   (say__ENA),
        .say_meth   (say_meth),
        .say_v      (say_v),
        .say__RDY   (say__RDY),
        .heard__ENA (heard__ENA),
        .heard_meth (heard_meth),
        .heard_v    (heard_v),
        .heard__RDY (heard__RDY),
        .rsp__ENA   (rsp__ENA),
        .rsp_meth   (rsp_meth),
        .rsp_v      (rsp_v),
        .rsp__RDY   (rsp__RDY),
        .busy       (busy)
`ifdef ECHO_REQ_ARBITER_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_fullstall (stat_fullstall)
`endif
    );

    logic [VW-1:0] obs_vec, exp_vec;
    assign obs_vec = {req__RDY, say__ENA, say_meth, say_v, heard__RDY,
                      rsp__ENA, rsp_meth, rsp_v, busy};

    // Reference model: outstanding tags, round-robin pointer, Echo queue
    typedef struct {
        logic [DW-1:0] meth;
        logic [DW-1:0] v;
        int            due;
    } echo_t;

    int          m_q[$];
    echo_t       echo_q[$];
    int          m_rr, cyc;
    int unsigned m_grants [NREQ];
    int unsigned m_stall;
    bit          echo_en;

    int              e_w, e_head;
    logic            e_say, e_hrdy, e_rsp_fire, e_stall, e_busy;
    logic [NREQ-1:0] e_req_rdy, e_rsp_ena;
    logic [DW-1:0]   e_say_meth, e_say_v, e_rsp_meth, e_rsp_v;

    int tests = 0;
    int fails = 0;

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i] === 1'b1) r = (r == -1) ? i : -2;
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        echo_q.delete();
        m_rr    = 0;
        m_stall = 0;
        for (int i = 0; i < NREQ; i++) m_grants[i] = 0;
    endtask

    task automatic model_eval();
        int sz;
        logic full, can, anyr;
        sz   = m_q.size();
        full = (sz == DEPTH);
        can  = say__RDY && !full;
        anyr = |drv_ena;
        e_w  = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_rr + k) % NREQ;
            if (e_w < 0 && drv_ena[idx]) e_w = idx;
        end
        e_say      = can && anyr;
        e_req_rdy  = '0;
        e_say_meth = '0;
        e_say_v    = '0;
        if (e_say) begin
            e_req_rdy[e_w] = 1'b1;
            e_say_meth     = drv_meth[e_w];
            e_say_v        = drv_v[e_w];
        end
        e_head     = (sz > 0) ? m_q[0] : 0;
        e_hrdy     = (sz > 0) && rsp__RDY[e_head];
        e_rsp_fire = heard__ENA && e_hrdy;
        e_rsp_ena  = '0;
        e_rsp_meth = '0;
        e_rsp_v    = '0;
        if (e_rsp_fire) begin
            e_rsp_ena[e_head] = 1'b1;
            e_rsp_meth        = heard_meth;
            e_rsp_v           = heard_v;
        end
        e_stall = anyr && full && say__RDY;
        e_busy  = (sz > 0);
        exp_vec = {e_req_rdy, e_say, e_say_meth, e_say_v, e_hrdy,
                   e_rsp_ena, e_rsp_meth, e_rsp_v, e_busy};
    endtask

    task automatic drive_echo();
        if (echo_en && echo_q.size() > 0 && echo_q[0].due <= cyc) begin
            heard__ENA = 1'b1;
            heard_meth = echo_q[0].meth;
            heard_v    = echo_q[0].v;
        end else begin
            heard__ENA = 1'b0;
            heard_meth = $urandom;
            heard_v    = $urandom;
        end
    endtask

    task automatic commit();
        if (e_say) begin
            echo_t it;
            m_q.push_back(e_w);
            m_rr    = (e_w + 1) % NREQ;
            it.meth = drv_meth[e_w];
            it.v    = drv_v[e_w];
            it.due  = cyc + 2;
            echo_q.push_back(it);
            if (m_grants[e_w] != 32'hFFFF) m_grants[e_w]++;
        end
        if (e_stall && m_stall != 32'hFFFF) m_stall++;
        if (e_rsp_fire) begin
            void'(m_q.pop_front());
            void'(echo_q.pop_front());
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic issue_one(input int r, output bit ok);
        ok          = 1'b0;
        drv_ena     = '0;
        drv_ena[r]  = 1'b1;
        drv_meth[r] = $urandom;
        drv_v[r]    = $urandom;
        for (int c = 0; c < 6 && !ok; c++) begin
            drive_echo();
            #1;
            model_eval();
            if (say__ENA === 1'b1 && req__RDY[r] === 1'b1) ok = 1'b1;
            commit();
        end
        drv_ena = '0;
    endtask

    task automatic drain();
        drv_ena  = '0;
        echo_en  = 1'b1;
        rsp__RDY = '1;
        for (int c = 0; c < 40 && (m_q.size() > 0 || echo_q.size() > 0); c++) begin
            drive_echo();
            #1;
            model_eval();
            commit();
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL drain: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        drv_ena    = '1;
        say__RDY   = 1'b1;
        rsp__RDY   = '1;
        heard__ENA = 1'b1;
        heard_meth = $urandom;
        heard_v    = $urandom;
        for (int i = 0; i < NREQ; i++) begin
            drv_meth[i] = $urandom;
            drv_v[i]    = $urandom;
        end
        repeat (2) @(posedge CLK);
        #1;
        tests++;
        if (req__RDY !== '0 || say__ENA !== 1'b0) begin
            fails++;
            $display("FAIL reset_issue: req__RDY=%b say__ENA=%b required 0", req__RDY, say__ENA);
        end
        tests++;
        if (heard__RDY !== 1'b0 || rsp__ENA !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_rsp: heard__RDY=%b rsp__ENA=%b busy=%b required 0",
                     heard__RDY, rsp__ENA, busy);
        end
        tests++;
        if (say_meth !== '0 || rsp_meth !== '0 || rsp_v !== '0) begin
            fails++;
            $display("FAIL reset_data: say_meth=%h rsp_meth=%h rsp_v=%h required 0",
                     say_meth, rsp_meth, rsp_v);
        end
        model_reset();
        cyc        = 0;
        heard__ENA = 1'b0;
        nRST       = 1'b1;
    endtask

    task automatic test_round_robin();
        int exp_g [5];
        int grant_q[$];
        int gi, g, r;
        exp_g = '{0, 1, 2, 3, 0};
        gi    = 0;
        for (int i = 0; i < NREQ; i++) begin
            drv_meth[i] = DW'(i);
            drv_v[i]    = DW'(32'h100 + i);
        end
        drv_ena  = '1;
        say__RDY = 1'b1;
        rsp__RDY = '1;
        echo_en  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c >= 8) drv_ena = '0;
            drive_echo();
            #1;
            model_eval();
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL rr_cycle %0d: got %h required %h", c, obs_vec, exp_vec);
            end
            if (say__ENA === 1'b1) begin
                g = onehot_idx(req__RDY);
                grant_q.push_back(g);
                if (gi < 5) begin
                    tests++;
                    if (g != exp_g[gi]) begin
                        fails++;
                        $display("FAIL rr_grant %0d: got %0d required %0d", gi, g, exp_g[gi]);
                    end
                    gi++;
                end
            end
            if (rsp__ENA !== '0) begin
                r = onehot_idx(rsp__ENA);
                tests++;
                if (grant_q.size() == 0 || r != grant_q[0] || rsp_meth !== DW'(r) ||
                    rsp_v !== DW'(32'h100 + r)) begin
                    fails++;
                    $display("FAIL rr_rsp: got req %0d meth %h v %h", r, rsp_meth, rsp_v);
                end
                if (grant_q.size() > 0) void'(grant_q.pop_front());
            end
            commit();
        end
        tests++;
        if (gi != 5) begin
            fails++;
            $display("FAIL rr_grant_count: got %0d required 5", gi);
        end
        drain();
    endtask

    task automatic test_full_stall();
        int fires;
        fires       = 0;
        drv_ena     = 4'b0100;
        drv_meth[2] = $urandom;
        drv_v[2]    = $urandom;
        say__RDY    = 1'b1;
        rsp__RDY    = '1;
        echo_en     = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive_echo();
            #1;
            model_eval();
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL full_cycle %0d: got %h required %h", c, obs_vec, exp_vec);
            end
            if (say__ENA === 1'b1 && req__RDY[2] === 1'b1) fires++;
            commit();
        end
        tests++;
        if (fires != DEPTH || req__RDY !== '0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL full_block: fires %0d req__RDY=%b busy=%b required %0d 0000 1",
                     fires, req__RDY, busy, DEPTH);
        end
        echo_en = 1'b1;
        drive_echo();
        #1;
        model_eval();
        tests++;
        if (heard__RDY !== 1'b1 || rsp__ENA !== 4'b0100 || req__RDY !== '0) begin
            fails++;
            $display("FAIL full_pop: heard__RDY=%b rsp__ENA=%b req__RDY=%b required 1 0100 0000",
                     heard__RDY, rsp__ENA, req__RDY);
        end
        commit();
        echo_en = 1'b0;
        drive_echo();
        #1;
        model_eval();
        tests++;
        if (req__RDY !== 4'b0100 || obs_vec !== exp_vec) begin
            fails++;
            $display("FAIL full_fifth: req__RDY=%b required 0100", req__RDY);
        end
        commit();
        drain();
    endtask

    task automatic test_rsp_backpressure();
        bit ok;
        echo_en  = 1'b0;
        rsp__RDY = '1;
        issue_one(1, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_issue1: no fire within bound");
        end
        issue_one(3, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_issue3: no fire within bound");
        end
        // Rewrite the stored v of requester 1's transaction to the plan's value
        echo_q[0].v = 32'hA5;
        rsp__RDY    = 4'b0101;
        echo_en     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_echo();
            #1;
            model_eval();
            tests++;
            if (heard__RDY !== 1'b0 || rsp__ENA !== '0 || obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL bp_hold %0d: heard__RDY=%b rsp__ENA=%b required 0 0000",
                         c, heard__RDY, rsp__ENA);
            end
            commit();
        end
        rsp__RDY = 4'b0111;
        drive_echo();
        #1;
        model_eval();
        tests++;
        if (rsp__ENA !== 4'b0010 || rsp_v !== 32'hA5 || obs_vec !== exp_vec) begin
            fails++;
            $display("FAIL bp_req1: rsp__ENA=%b rsp_v=%h required 0010 000000a5", rsp__ENA, rsp_v);
        end
        commit();
        drive_echo();
        #1;
        model_eval();
        tests++;
        if (heard__RDY !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL bp_req3_hold: heard__RDY=%b busy=%b required 0 1", heard__RDY, busy);
        end
        commit();
        rsp__RDY = '1;
        drive_echo();
        #1;
        model_eval();
        tests++;
        if (rsp__ENA !== 4'b1000 || obs_vec !== exp_vec) begin
            fails++;
            $display("FAIL bp_req3: rsp__ENA=%b required 1000", rsp__ENA);
        end
        commit();
        drain();
    endtask

    task automatic test_same_cycle();
        bit ok0, ok1;
        int fires;
        echo_en  = 1'b0;
        rsp__RDY = '1;
        issue_one(0, ok0);
        issue_one(1, ok1);
        tests++;
        if (!ok0 || !ok1) begin
            fails++;
            $display("FAIL same_setup: fires %b%b required 11", ok0, ok1);
        end
        drv_ena     = 4'b0100;
        drv_meth[2] = $urandom;
        drv_v[2]    = $urandom;
        echo_en     = 1'b1;
        drive_echo();
        #1;
        model_eval();
        tests++;
        if (req__RDY !== 4'b0100 || say__ENA !== 1'b1 || rsp__ENA !== 4'b0001 ||
            obs_vec !== exp_vec) begin
            fails++;
            $display("FAIL same_fire: req__RDY=%b say__ENA=%b rsp__ENA=%b required 0100 1 0001",
                     req__RDY, say__ENA, rsp__ENA);
        end
        commit();
        // Two slots left means exactly two more fires before the FIFO blocks
        echo_en = 1'b0;
        drv_ena = 4'b0001;
        fires   = 0;
        for (int c = 0; c < 4; c++) begin
            drive_echo();
            #1;
            model_eval();
            if (say__ENA === 1'b1) fires++;
            commit();
        end
        tests++;
        if (fires != 2) begin
            fails++;
            $display("FAIL same_count: got %0d free slots required 2", fires);
        end
        drain();
    endtask

    task automatic test_async_reset();
        bit ok;
        int good;
        good    = 0;
        echo_en = 1'b0;
        for (int r = 0; r < 3; r++) begin
            issue_one(r, ok);
            if (ok) good++;
        end
        tests++;
        if (good != 3 || busy !== 1'b1) begin
            fails++;
            $display("FAIL areset_setup: fires %0d busy=%b required 3 1", good, busy);
        end
        drv_ena    = '1;
        say__RDY   = 1'b1;
        rsp__RDY   = '1;
        heard__ENA = 1'b1;
        #2;
        nRST = 1'b0;
        #1;
        tests++;
        if (req__RDY !== '0 || say__ENA !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL areset_issue: req__RDY=%b say__ENA=%b busy=%b required 0",
                     req__RDY, say__ENA, busy);
        end
        tests++;
        if (heard__RDY !== 1'b0 || rsp__ENA !== '0) begin
            fails++;
            $display("FAIL areset_rsp: heard__RDY=%b rsp__ENA=%b required 0", heard__RDY, rsp__ENA);
        end
        model_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        drive_echo();
        #1;
        model_eval();
        tests++;
        if (req__RDY !== 4'b0001 || obs_vec !== exp_vec) begin
            fails++;
            $display("FAIL areset_first: req__RDY=%b required 0001", req__RDY);
        end
        commit();
        drain();
    endtask

    task automatic test_random();
        bit fired [NREQ];
        for (int i = 0; i < NREQ; i++) fired[i] = 1'b1;
        drv_ena = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!drv_ena[i] || fired[i]) begin
                    drv_ena[i]  = $urandom_range(0, 1);
                    drv_meth[i] = $urandom;
                    drv_v[i]    = $urandom;
                end
            end
            say__RDY = ($urandom_range(0, 3) != 0);
            rsp__RDY = NREQ'($urandom);
            echo_en  = ($urandom_range(0, 2) != 0);
            drive_echo();
            #1;
            model_eval();
            tests++;
            if (obs_vec !== exp_vec) begin
                fails++;
                $display("FAIL random_cycle %0d: got %h required %h", c, obs_vec, exp_vec);
            end
            for (int i = 0; i < NREQ; i++) fired[i] = e_say && (e_w == i);
            commit();
        end
        say__RDY = 1'b1;
        drain();
    endtask

`ifdef ECHO_REQ_ARBITER_STATS_EN
    task automatic test_stats();
        for (int i = 0; i < NREQ; i++) begin
            tests++;
            if (stat_grants[i*16 +: 16] !== 16'(m_grants[i])) begin
                fails++;
                $display("FAIL stat_grants %0d: got %0d required %0d",
                         i, stat_grants[i*16 +: 16], m_grants[i]);
            end
        end
        tests++;
        if (stat_fullstall !== 16'(m_stall)) begin
            fails++;
            $display("FAIL stat_fullstall: got %0d required %0d", stat_fullstall, m_stall);
        end
        drv_ena     = 4'b0001;
        drv_meth[0] = 32'h0;
        drv_v[0]    = 32'h100;
        say__RDY    = 1'b1;
        rsp__RDY    = '1;
        echo_en     = 1'b1;
        for (int c = 0; c < 70000; c++) begin
            drive_echo();
            #1;
            model_eval();
            commit();
        end
        tests++;
        if (stat_grants[15:0] !== 16'hFFFF) begin
            fails++;
            $display("FAIL stat_saturate: got %h required ffff", stat_grants[15:0]);
        end
        drain();
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        cyc      = 0;
        echo_en  = 1'b0;
        test_reset();
        test_round_robin();
        test_full_stall();
        test_rsp_backpressure();
        test_same_cycle();
        test_random();
`ifdef ECHO_REQ_ARBITER_STATS_EN
        test_stats();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/echo_req_arbiter.md
Name: echo_req_arbiter

Overview:
- Shares one Echo-style say/heard service among NREQ requesters.
- Round-robin arbitrates say requests, records the winner's index in an in-order tag FIFO, and routes each returning heard indication back to the requester that issued it.
- Sits between client modules and the Echo instance.
- Relies on the Echo service answering strictly in request order.

Parameters:
- NREQ, 4: number of requesters (2..8).
- DEPTH, 4: max outstanding say transactions; tag FIFO depth (power of 2, at least 2).
- DW, 32: width of meth and v fields.

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset; asynchronous, active-low.
- req__ENA  input  NREQ  per-requester say request valid; held with data until req__RDY.
- req_meth  input  NREQ*DW  packed meth, requester i at [i*DW +: DW].
- req_v  input  NREQ*DW  packed v.
- req__RDY  output  NREQ  one-hot grant; request i fires when req__ENA[i] && req__RDY[i].
- say__ENA  output  1  to Echo say.
- say_meth  output  DW  to Echo say.
- say_v  output  DW  to Echo say.
- say__RDY  input  1  from Echo.
- heard__ENA  input  1  from Echo indication.
- heard_meth  input  DW  from Echo indication.
- heard_v  input  DW  from Echo indication.
- heard__RDY  output  1  to Echo.
- rsp__ENA  output  NREQ  one-hot response strobe.
- rsp_meth  output  DW  shared response bus.
- rsp_v  output  DW  shared response bus.
- rsp__RDY  input  NREQ  per-requester response ready.
- busy  output  1  at least one transaction is outstanding.

Behaviour:
- Reset (nRST low, asynchronous):
  - rr_ptr=0, FIFO empty (count=0, rd/wr ptr=0).
  - All outputs that depend only on state are 0.
  - req__RDY, say__ENA, heard__RDY and rsp__ENA are 0 immediately, because each one depends on can_issue or FIFO not-empty.
- Issue path, combinational, zero latency:
  - can_issue = say__RDY && (count != DEPTH).
  - Winner = first i with req__ENA[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req__RDY[winner] = can_issue; all other req__RDY bits are 0.
  - req__RDY never depends on req__ENA of the same requester, except through winner selection.
  - say__ENA = can_issue && any req__ENA.
  - say_meth/say_v = winner's fields when say__ENA=1, otherwise 0.
- On issue fire, at the clock edge:
  - Push the winner index into the FIFO.
  - rr_ptr <= (winner+1) mod NREQ.
  - rr_ptr is unchanged when nothing fires.
- Response path, combinational:
  - head = FIFO output.
  - heard__RDY = (count != 0) && rsp__RDY[head].
  - rsp__ENA[head] = heard__ENA && heard__RDY; other bits 0.
  - rsp_meth/rsp_v = heard_* when rsp__ENA is nonzero, otherwise 0.
  - On fire, pop the FIFO.
- Simultaneous issue and response in one cycle: push and pop both occur; count is unchanged.
  - When full, a same-cycle pop does not unblock the issue; can_issue uses the registered count only.
- Empty FIFO: heard__RDY=0, so a stray heard__ENA is never accepted.
- Wrap-around: FIFO pointers wrap mod DEPTH; rr_ptr wraps mod NREQ.
- busy = (count != 0).
- Reset mid-operation: outstanding tags are discarded. The Echo instance shares nRST, so no orphan responses arrive.

Optional Feature:
- Macro: ECHO_REQ_ARBITER_STATS_EN.
- When defined:
  - Adds output stat_grants, NREQ*16 wide, one 16-bit counter per requester.
  - Adds output stat_fullstall, 16 wide.
  - Counter i increments on each issue fire by requester i.
  - stat_fullstall increments each cycle with any req__ENA && count==DEPTH && say__RDY.
  - All counters saturate at 16'hFFFF and reset to 0.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package echo_arb_pkg:
  - Function clog2.
  - Localparams TAG_W=clog2(NREQ), CNT_W=clog2(DEPTH)+1, STAT_W=16.
  - Function rr_pick(req, ptr) returning the winner index and a valid bit.
- Sub-module echo_tag_fifo (WIDTH=TAG_W, DEPTH): synchronous FIFO with push, pop, head, count, full and empty outputs, asynchronous active-low reset. Same-cycle push and pop are allowed when neither full nor empty.

Test Plan:
- Reset, then NREQ=4 with req__ENA=4'b1111 held and say__RDY=1, Echo model with 2-cycle latency:
  - Grants go 0,1,2,3,0 on successive fires.
  - Each rsp__ENA goes to the matching requester with meth/v echoed (requester i sends meth=i, v=32'h100+i).
- Requester 2 only, say__RDY=1, Echo heard__ENA held 0:
  - After 4 fires, req__RDY=0 and busy=1.
  - A fifth fire occurs only in the cycle after the first heard fires.
- Requester 1 and requester 3 responses queued, rsp__RDY=4'b0101 (requester 1 not ready):
  - heard__RDY=0 and nothing is popped.
  - After raising rsp__RDY[1], requester 1 gets the response with v=32'hA5, then requester 3.
- Issue and response in the same cycle at count=2 → count stays 2 and both requesters see their fire.
- nRST asserted asynchronously mid-clock with count=3 → req__RDY, rsp__RDY-driven outputs and busy go 0 without a clock edge; after release, rr_ptr=0 and requester 0 wins first.
- With ECHO_REQ_ARBITER_STATS_EN defined:
  - 70000 grants to requester 0 leaves stat_grants[15:0]=16'hFFFF.
  - stat_fullstall counts the 3 blocked cycles of the full scenario.
